// File: rtl/enigma_pkg.sv
// Shared widths and types for the enigma output path.
package enigma_pkg;
    localparam int SYMB_W = 7;
    localparam int CNT_W  = 8;

    typedef logic signed [SYMB_W-1:0] symb_t;
    typedef enum logic {IDLE, RECV} sink_state_t;
endpackage

// File: rtl/enigma_sync_fifo.sv
// Synchronous FWFT FIFO; push visible at head one cycle later.
// Push while full is dropped (full taken before this cycle's pop); pop while empty is ignored.
module enigma_sync_fifo #(
    parameter int  DEPTH  = 128,
    parameter type data_t = logic [7:0]
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  push,
    input  data_t push_dat,
    input  logic  pop,
    output logic  full,
    output logic  empty,
    output data_t head_dat
);
    localparam int AW = $clog2(DEPTH);

    data_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    // Head reads as zero when empty so the port is all-zero out of reset.
    assign head_dat = empty ? data_t'(0) : mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/enigma_frame_sink.sv
// Collects a framed symbol stream into a FIFO and flags completion/overflow/length errors.
// Symbols reach the read port one cycle after capture; a full FIFO drops symbols (sticky ovf).
module enigma_frame_sink
    import enigma_pkg::*;
#(
    parameter int DEPTH = 128
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             frame_start_i,
    input  logic [CNT_W-1:0] symb_numb_i,
    input  logic             symb_val_i,
    input  symb_t            symbol_i,
    output logic             rd_val_o,
    output symb_t            rd_symbol_o,
    input  logic             rd_rdy_i,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic [CNT_W-1:0] rcv_cnt_o,
    output logic             ovf_o,
    output logic             len_err_o
);
    sink_state_t      state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             lerr_q, lerr_d;
    logic             done_q, done_d;

    logic             active;
    logic             take;
    logic             push;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] n_eff;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        // A start in the same cycle as a symbol makes that symbol the first of the new frame.
        active   = frame_start_i || (state_q == RECV);
        n_eff    = frame_start_i ? symb_numb_i : n_q;
        cnt_base = frame_start_i ? '0 : cnt_q;
        cnt_inc  = (cnt_base == '1) ? cnt_base : cnt_base + CNT_W'(1);
        take     = active && symb_val_i && (n_eff != '0);
        push     = take && !fifo_full;
        n_d      = n_eff;
        cnt_d    = take ? cnt_inc : cnt_base;

        ovf_d = (frame_start_i && state_q == IDLE) ? 1'b0 : ovf_q;
        if (take && fifo_full) begin
            ovf_d = 1'b1;
        end

        if (frame_start_i) begin
            lerr_d = (state_q == RECV);
        end else begin
            lerr_d = lerr_q;
        end
        if (symb_val_i && !take) begin
            lerr_d = 1'b1;
        end

        if (active) begin
            if ((n_eff == '0) || (take && cnt_inc == n_eff)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = RECV;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            lerr_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            lerr_q  <= lerr_d;
            done_q  <= done_d;
        end
    end

    enigma_sync_fifo #(
        .DEPTH  (DEPTH),
        .data_t (symb_t)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push     (push),
        .push_dat (symbol_i),
        .pop      (rd_rdy_i),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_dat (rd_symbol_o)
    );

    assign rd_val_o     = !fifo_empty;
    assign busy_o       = (state_q == RECV);
    assign frame_done_o = done_q;
    assign rcv_cnt_o    = cnt_q;
    assign ovf_o        = ovf_q;
    assign len_err_o    = lerr_q;
endmodule

// File: tb/tb_enigma_frame_sink.sv
// Bench for enigma_frame_sink: per-cycle vector table plus scoreboard on the read port.
module tb_enigma_frame_sink;
    import enigma_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst = 1'b0;
    logic               frame_start = 1'b0;
    logic [7:0]         symb_numb = '0;
    logic               symb_val = 1'b0;
    logic signed [6:0]  symbol = '0;
    logic               rd_rdy = 1'b0;
    logic               rd_val;
    logic signed [6:0]  rd_symbol;
    logic               busy;
    logic               frame_done;
    logic [7:0]         rcv_cnt;
    logic               ovf;
    logic               len_err;

    enigma_frame_sink #(.DEPTH(128)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .frame_start_i (frame_start),
        .symb_numb_i   (symb_numb),
        .symb_val_i    (symb_val),
        .symbol_i      (symbol),
        .rd_val_o      (rd_val),
        .rd_symbol_o   (rd_symbol),
        .rd_rdy_i      (rd_rdy),
        .busy_o        (busy),
        .frame_done_o  (frame_done),
        .rcv_cnt_o     (rcv_cnt),
        .ovf_o         (ovf),
        .len_err_o     (len_err)
    );

    typedef struct {
        bit s; int n; bit v; int sym; bit rdy; bit push;
        int busy; int done; int cnt; int ovf; int lerr; int rv;
    } vec_t;

    vec_t tbl[$];
    int   sb[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   n_read = 0;

    task automatic chk(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic add(bit s, int n, bit v, int sym, bit rdy, bit push,
                       int b, int d, int c, int o, int l, int rv);
        vec_t r;
        r.s = s; r.n = n; r.v = v; r.sym = sym; r.rdy = rdy; r.push = push;
        r.busy = b; r.done = d; r.cnt = c; r.ovf = o; r.lerr = l; r.rv = rv;
        tbl.push_back(r);
    endtask

    task automatic drive(bit s, int n, bit v, int sym, bit rdy);
        frame_start = s;
        symb_numb   = 8'(n);
        symb_val    = v;
        symbol      = 7'(sym);
        rd_rdy      = rdy;
    endtask

    // Inputs change at posedge+1; outputs are checked at the next posedge+1.
    task automatic run_rows(int lo, int hi);
        for (int i = lo; i <= hi; i++) begin
            drive(tbl[i].s, tbl[i].n, tbl[i].v, tbl[i].sym, tbl[i].rdy);
            if (tbl[i].push) sb.push_back(tbl[i].sym);
            @(posedge clk); #1;
            chk($sformatf("r%0d_busy", i), int'(busy), tbl[i].busy);
            chk($sformatf("r%0d_done", i), int'(frame_done), tbl[i].done);
            chk($sformatf("r%0d_cnt", i), int'(rcv_cnt), tbl[i].cnt);
            chk($sformatf("r%0d_ovf", i), int'(ovf), tbl[i].ovf);
            chk($sformatf("r%0d_lerr", i), int'(len_err), tbl[i].lerr);
            if (tbl[i].rv >= 0) chk($sformatf("r%0d_rdval", i), int'(rd_val), tbl[i].rv);
        end
        drive(0, 0, 0, 0, rd_rdy);
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(frame_done), 0);
        chk({tag, "_cnt"}, int'(rcv_cnt), 0);
        chk({tag, "_ovf"}, int'(ovf), 0);
        chk({tag, "_lerr"}, int'(len_err), 0);
        chk({tag, "_rdval"}, int'(rd_val), 0);
        chk({tag, "_rdsym"}, int'(rd_symbol), 0);
    endtask

    always @(negedge clk) begin
        if (rst && rd_val && rd_rdy) begin
            n_read++;
            if (sb.size() == 0) begin
                chk("rd_unexpected_read", 1, 0);
            end else begin
                chk("rd_symbol", int'(rd_symbol), sb.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int reads0;

        //   s  n  v  sym rdy psh | busy done cnt ovf lerr rv
        // basic frame of three, consumer always ready
        add(1, 3, 0,   0, 1, 0,   1, 0, 0, 0, 0, 0);   // 0
        add(0, 0, 1,   5, 1, 1,   1, 0, 1, 0, 0, 1);
        add(0, 0, 1,  -3, 1, 1,   1, 0, 2, 0, 0, 1);
        add(0, 0, 1,  63, 1, 1,   0, 1, 3, 0, 0, 1);
        add(0, 0, 0,   0, 1, 0,   0, 0, 3, 0, 0, 0);   // 4
        // stray symbol in IDLE
        add(0, 0, 1,   9, 1, 0,   0, 0, 3, 0, 1, 0);
        add(0, 0, 0,   0, 1, 0,   0, 0, 3, 0, 1, 0);
        // zero-length frame
        add(1, 0, 0,   0, 1, 0,   0, 1, 0, 0, 0, 0);
        add(0, 0, 0,   0, 1, 0,   0, 0, 0, 0, 0, 0);
        // early restart, consumer stalled, then four drains empty the FIFO
        add(1, 5, 0,   0, 0, 0,   1, 0, 0, 0, 0, 0);   // 9
        add(0, 0, 1,  10, 0, 1,   1, 0, 1, 0, 0, 1);
        add(0, 0, 1,  11, 0, 1,   1, 0, 2, 0, 0, 1);
        add(1, 2, 0,   0, 0, 0,   1, 0, 0, 0, 1, 1);
        add(0, 0, 1,  12, 0, 1,   1, 0, 1, 0, 1, 1);
        add(0, 0, 1, -12, 0, 1,   0, 1, 2, 0, 1, 1);
        add(0, 0, 0,   0, 1, 0,   0, 0, 2, 0, 1, 1);
        add(0, 0, 0,   0, 1, 0,   0, 0, 2, 0, 1, 1);
        add(0, 0, 0,   0, 1, 0,   0, 0, 2, 0, 1, 1);
        add(0, 0, 0,   0, 1, 0,   0, 0, 2, 0, 1, 0);   // 18
        // start and symbol together with N=1 completes at once
        add(1, 1, 1,   7, 1, 1,   0, 1, 1, 0, 0, 1);
        add(0, 0, 0,   0, 1, 0,   0, 0, 1, 0, 0, 0);   // 20

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        run_rows(0, 20);

        // overflow: 130 symbols into 128 entries with the consumer stalled
        drive(1, 130, 0, 0, 0);
        @(posedge clk); #1;
        chk("ovf_busy", int'(busy), 1);
        for (int i = 0; i < 130; i++) begin
            drive(0, 0, 1, i % 64, 0);
            if (i < 128) sb.push_back(i % 64);
            @(posedge clk); #1;
            if (i == 0)   chk("ovf_first_rdval", int'(rd_val), 1);
            if (i == 127) chk("ovf_before_full", int'(ovf), 0);
            if (i == 128) chk("ovf_set", int'(ovf), 1);
            if (i == 129) begin
                chk("ovf_done", int'(frame_done), 1);
                chk("ovf_cnt", int'(rcv_cnt), 130);
                chk("ovf_busy_end", int'(busy), 0);
                chk("ovf_sticky", int'(ovf), 1);
            end
        end
        reads0 = n_read;
        drive(0, 0, 0, 0, 1);
        for (int c = 0; c < 400 && sb.size() != 0; c++) @(posedge clk);
        chk("ovf_drain_left", sb.size(), 0);
        @(posedge clk); #1;
        chk("ovf_drain_reads", n_read - reads0, 128);
        chk("ovf_drain_empty", int'(rd_val), 0);

        // asynchronous reset mid-frame
        drive(1, 10, 0, 0, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 20 + i, 0);
            @(posedge clk); #1;
        end
        chk("rst_mid_busy_before", int'(busy), 1);
        chk("rst_mid_cnt_before", int'(rcv_cnt), 4);
        drive(0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        sb.delete();
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        run_rows(0, 4);

        repeat (3) @(posedge clk);
        #1;
        chk("final_sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
